// File: rtl/panel_input_pkg.sv
// Shared definitions for the front-panel input conditioner: status-word field
// positions, reset value and quadrature state encodings.
package panel_input_pkg;

  localparam int NUM_BUTTONS = 13;
  localparam int NUM_ENC     = 2;

  // Status word field positions
  localparam int BUT_LSB     = 0;
  localparam int BUT_MSB     = 12;
  localparam int ONES_LO_LSB = 13;
  localparam int ONES_LO_MSB = 15;
  localparam int REX1_BIT    = 16;
  localparam int REX2_BIT    = 17;
  localparam int RIN1_BIT    = 18;
  localparam int RIN2_BIT    = 19;
  localparam int ENC0_LSB    = 20;
  localparam int ENC0_MSB    = 23;
  localparam int ENC1_LSB    = 24;
  localparam int ENC1_MSB    = 27;
  localparam int ONES_HI_LSB = 28;
  localparam int ONES_HI_MSB = 30;
  localparam int IDLE_BIT    = 31;

  localparam logic [31:0] PORT_RESET_VAL = 32'hF00F_FFFF;
  // Only debounced buttons and encoder positions raise change_o
  localparam logic [31:0] CHANGE_MASK    = 32'h0FF0_1FFF;

  typedef enum logic [1:0] {
    QUAD_00 = 2'b00,
    QUAD_01 = 2'b01,
    QUAD_11 = 2'b11,
    QUAD_10 = 2'b10
  } quad_state_e;

  localparam quad_state_e QUAD_RESET = QUAD_11;

  typedef enum logic [1:0] {
    QDIR_HOLD,
    QDIR_UP,
    QDIR_DOWN
  } quad_dir_e;

  function automatic quad_state_e quad_fwd(input quad_state_e s);
    case (s)
      QUAD_00: return QUAD_01;
      QUAD_01: return QUAD_11;
      QUAD_11: return QUAD_10;
      default: return QUAD_00;
    endcase
  endfunction

  // A double-bit change matches neither neighbour and decodes as hold
  function automatic quad_dir_e quad_decode(input quad_state_e prev, input quad_state_e curr);
    if (curr == quad_fwd(prev)) return QDIR_UP;
    if (prev == quad_fwd(curr)) return QDIR_DOWN;
    return QDIR_HOLD;
  endfunction

endpackage

// File: rtl/panel_debounce.sv
// One-button conditioner: 2-flop synchroniser (idle-high) followed by a
// debouncer that accepts a new level after DEBOUNCE_CYCLES consecutive cycles.
module panel_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             stable_reg;
  logic             stable_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    stable_next = stable_reg;
    cnt_next    = '0;
    if (sync2_reg != stable_reg) begin
      // Any cycle where sync agrees with stable restarts the count
      if (cnt_reg == CNT_LAST) stable_next = sync2_reg;
      else                     cnt_next    = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg  <= 1'b1;
      sync2_reg  <= 1'b1;
      stable_reg <= 1'b1;
      cnt_reg    <= '0;
    end else begin
      sync1_reg  <= raw;
      sync2_reg  <= sync1_reg;
      stable_reg <= stable_next;
      cnt_reg    <= cnt_next;
    end
  end

  assign stable = stable_reg;

endmodule

// File: rtl/panel_input_conditioner.sv
// Front-panel conditioner: debounced buttons, two quadrature position counters
// and the registered 32-bit status word. Define PANEL_INPUT_IRQ_EN for the sticky irq.
module panel_input_conditioner
  import panel_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic        PLD_MCLK,
  input  logic        EPL_RESETN,
  input  logic [12:0] but_raw_i,
  input  logic        enc0_a_i,
  input  logic        enc0_b_i,
  input  logic        enc1_a_i,
  input  logic        enc1_b_i,
  output logic [31:0] port_o,
  output logic        change_o,
  input  logic        irq_clr_i,
  output logic        irq_o
);

  logic [NUM_BUTTONS-1:0] but_stable;
  // Ordered to match status bits [19:16]: REX1, REX2, RIN1, RIN2
  logic [3:0]             enc_raw;
  logic [3:0]             enc_sync1_reg;
  logic [3:0]             enc_sync2_reg;
  logic [3:0]             enc_pos [NUM_ENC];
  logic [31:0]            port_reg;
  logic [31:0]            port_next;
  logic                   change_reg;
  logic                   change_next;

  generate
    for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_button
      panel_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_debounce (
        .clk    (PLD_MCLK),
        .rst_n  (EPL_RESETN),
        .raw    (but_raw_i[gi]),
        .stable (but_stable[gi])
      );
    end
  endgenerate

  assign enc_raw = {enc0_b_i, enc0_a_i, enc1_b_i, enc1_a_i};

  always_ff @(posedge PLD_MCLK or negedge EPL_RESETN) begin
    if (!EPL_RESETN) begin
      enc_sync1_reg <= '1;
      enc_sync2_reg <= '1;
    end else begin
      enc_sync1_reg <= enc_raw;
      enc_sync2_reg <= enc_sync1_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_ENC; gi++) begin : g_encoder
      // Encoder 0 (RIN) sits in sync bits [3:2], encoder 1 (REX) in [1:0]
      localparam int A_IDX = (gi == 0) ? 2 : 0;

      quad_state_e quad_prev_reg;
      quad_state_e quad_curr;
      logic [3:0]  pos_reg;
      logic [3:0]  pos_next;

      assign quad_curr = quad_state_e'({enc_sync2_reg[A_IDX], enc_sync2_reg[A_IDX+1]});

      always_comb begin
        pos_next = pos_reg;
        case (quad_decode(quad_prev_reg, quad_curr))
          QDIR_UP:   pos_next = pos_reg + 4'd1;
          QDIR_DOWN: pos_next = pos_reg - 4'd1;
          default:   pos_next = pos_reg;
        endcase
      end

      always_ff @(posedge PLD_MCLK or negedge EPL_RESETN) begin
        if (!EPL_RESETN) begin
          quad_prev_reg <= QUAD_RESET;
          pos_reg       <= '0;
        end else begin
          quad_prev_reg <= quad_curr;
          pos_reg       <= pos_next;
        end
      end

      assign enc_pos[gi] = pos_reg;
    end
  endgenerate

  always_comb begin
    port_next                          = '1;
    port_next[BUT_MSB:BUT_LSB]         = but_stable;
    port_next[ONES_LO_MSB:ONES_LO_LSB] = '1;
    port_next[REX1_BIT]                = enc_sync2_reg[0];
    port_next[REX2_BIT]                = enc_sync2_reg[1];
    port_next[RIN1_BIT]                = enc_sync2_reg[2];
    port_next[RIN2_BIT]                = enc_sync2_reg[3];
    port_next[ENC0_MSB:ENC0_LSB]       = enc_pos[0];
    port_next[ENC1_MSB:ENC1_LSB]       = enc_pos[1];
    port_next[ONES_HI_MSB:ONES_HI_LSB] = '1;
    port_next[IDLE_BIT]                = &{but_stable, enc_sync2_reg};
  end

  assign change_next = |((port_next ^ port_reg) & CHANGE_MASK);

  always_ff @(posedge PLD_MCLK or negedge EPL_RESETN) begin
    if (!EPL_RESETN) begin
      port_reg   <= PORT_RESET_VAL;
      change_reg <= 1'b0;
    end else begin
      port_reg   <= port_next;
      change_reg <= change_next;
    end
  end

  assign port_o   = port_reg;
  assign change_o = change_reg;

`ifdef PANEL_INPUT_IRQ_EN
  logic irq_reg;

  // Set has priority so a change arriving with a clear is never lost
  always_ff @(posedge PLD_MCLK or negedge EPL_RESETN) begin
    if (!EPL_RESETN)     irq_reg <= 1'b0;
    else if (change_reg) irq_reg <= 1'b1;
    else if (irq_clr_i)  irq_reg <= 1'b0;
  end

  assign irq_o = irq_reg;
`else
  logic unused_irq_clr;

  assign unused_irq_clr = irq_clr_i;
  assign irq_o          = 1'b0;
`endif

endmodule
